// File: rtl/pic_pkg.sv
// pic_pkg: shared state encoding and ICW/OCW bit positions for the PIC acknowledge controller.
`default_nettype none

package pic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      ACK2 = 2'd2
   } state_t;

   localparam int LTIM_BIT = 3;
   localparam int SNGL_BIT = 1;
   localparam int AEOI_BIT = 1;

   localparam int ICW1_F = 0;
   localparam int ICW2_F = 1;
   localparam int ICW3_F = 2;
   localparam int ICW4_F = 3;

endpackage

`default_nettype wire

// File: rtl/pic_inta_edge.sv
// pic_inta_edge: registers INTA and produces one-cycle fall/rise indications.
`default_nettype none

module pic_inta_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic inta_n,
   output logic fall,
   output logic rise
);

   logic inta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inta_q <= 1'b1;
      else        inta_q <= inta_n;
   end

   assign fall = inta_q & ~inta_n;
   assign rise = ~inta_q & inta_n;

endmodule

`default_nettype wire

// File: rtl/pic_ack_ctrl.sv
// pic_ack_ctrl: ICW/OCW1 registers, two-pulse INTA sequencer and vector build.
// Cascade drive/compare and ICW3 are present only when PIC_CASCADE_EN is defined.
`default_nettype none

module pic_ack_ctrl
   import pic_pkg::*;
#(
   parameter int NUM_IR = 8,
   parameter int VEC_W  = 8,
   parameter int CAS_W  = 3,
   localparam int IDX_W = $clog2(NUM_IR)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inta_n,
   input  logic             sp_n,
   input  logic [3:0]       icw_wr,
   input  logic             ocw1_wr,
   input  logic [VEC_W-1:0] data_in,
   input  logic             int_req,
   input  logic [IDX_W-1:0] int_idx,
   input  logic [CAS_W-1:0] cas_in,
   output logic [CAS_W-1:0] cas_out,
   output logic             cas_oe,
   output logic [NUM_IR-1:0] imr,
   output logic             aeoi,
   output logic             ltim,
   output logic             first_ack,
   output logic             second_ack,
   output logic [VEC_W-1:0] iv,
   output logic             iv_ready,
   output logic             eoi_pulse,
   output logic [IDX_W-1:0] ack_idx
);

   state_t state, next_state;
   logic fall, rise;
   logic go_ack1, go_ack2, go_idle;
   logic single;
   logic [VEC_W-IDX_W-1:0] base;
   logic [IDX_W-1:0] idx_sel;
   logic drive_cas, sel;

   pic_inta_edge u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .inta_n (inta_n),
      .fall   (fall),
      .rise   (rise)
   );

   // With no request pending the acknowledge reports the lowest-priority line.
   assign idx_sel = int_req ? int_idx : IDX_W'(NUM_IR - 1);

`ifdef PIC_CASCADE_EN
   logic [NUM_IR-1:0] icw3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                icw3 <= '0;
      else if (icw_wr[ICW1_F])   icw3 <= '0;
      else if (icw_wr[ICW3_F])   icw3 <= NUM_IR'(data_in);
   end

   assign drive_cas = sp_n & ~single & icw3[idx_sel];
   assign sel       = single | (sp_n ? ~icw3[ack_idx] : (cas_in == icw3[CAS_W-1:0]));
`else
   logic unused_cas;
   assign unused_cas = ^{icw_wr[ICW3_F], sp_n, cas_in, single};
   assign drive_cas  = 1'b0;
   assign sel        = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      go_ack1    = 1'b0;
      go_ack2    = 1'b0;
      go_idle    = 1'b0;
      case (state)
         IDLE: if (fall) begin next_state = ACK1; go_ack1 = 1'b1; end
         ACK1: if (fall) begin next_state = ACK2; go_ack2 = 1'b1; end
         ACK2: if (rise) begin next_state = IDLE; go_idle = 1'b1; end
         default: next_state = IDLE;
      endcase
      // Re-initialisation overrides any acknowledge in flight.
      if (icw_wr[ICW1_F]) begin
         next_state = IDLE;
         go_ack1    = 1'b0;
         go_ack2    = 1'b0;
         go_idle    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         single     <= 1'b0;
         ltim       <= 1'b0;
         base       <= '0;
         aeoi       <= 1'b0;
         imr        <= '0;
         first_ack  <= 1'b0;
         second_ack <= 1'b0;
         eoi_pulse  <= 1'b0;
         ack_idx    <= '0;
         cas_out    <= '0;
         cas_oe     <= 1'b0;
         iv         <= '0;
         iv_ready   <= 1'b0;
      end else begin
         first_ack  <= go_ack1;
         second_ack <= go_ack2;
         eoi_pulse  <= go_idle & aeoi;
         if (icw_wr[ICW1_F]) begin
            single   <= data_in[SNGL_BIT];
            ltim     <= data_in[LTIM_BIT];
            base     <= '0;
            aeoi     <= 1'b0;
            imr      <= '0;
            iv_ready <= 1'b0;
            cas_oe   <= 1'b0;
         end else begin
            if (icw_wr[ICW2_F]) base <= data_in[VEC_W-1:IDX_W];
            if (icw_wr[ICW4_F]) aeoi <= data_in[AEOI_BIT];
            if (ocw1_wr)        imr  <= NUM_IR'(data_in);
            if (go_ack1) begin
               ack_idx <= idx_sel;
               if (drive_cas) begin
                  cas_out <= CAS_W'(idx_sel);
                  cas_oe  <= 1'b1;
               end
            end
            if (go_ack2) begin
               iv       <= {base, ack_idx};
               iv_ready <= sel;
            end
            if (go_idle) begin
               iv_ready <= 1'b0;
               cas_oe   <= 1'b0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pic_ack_ctrl.sv
// tb_pic_ack_ctrl: directed self-checking bench for pic_ack_ctrl (NUM_IR=8, VEC_W=8, CAS_W=3).
`default_nettype none

module tb_pic_ack_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inta_n = 1'b1;
   logic       sp_n = 1'b1;
   logic [3:0] icw_wr = '0;
   logic       ocw1_wr = 1'b0;
   logic [7:0] data_in = '0;
   logic       int_req = 1'b0;
   logic [2:0] int_idx = '0;
   logic [2:0] cas_in = '0;
   logic [2:0] cas_out;
   logic       cas_oe;
   logic [7:0] imr;
   logic       aeoi, ltim, first_ack, second_ack, iv_ready, eoi_pulse;
   logic [7:0] iv;
   logic [2:0] ack_idx;

   int total = 0;
   int bad = 0;

   pic_ack_ctrl #(.NUM_IR(8), .VEC_W(8), .CAS_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .sp_n(sp_n),
      .icw_wr(icw_wr), .ocw1_wr(ocw1_wr), .data_in(data_in),
      .int_req(int_req), .int_idx(int_idx), .cas_in(cas_in),
      .cas_out(cas_out), .cas_oe(cas_oe), .imr(imr), .aeoi(aeoi), .ltim(ltim),
      .first_ack(first_ack), .second_ack(second_ack), .iv(iv),
      .iv_ready(iv_ready), .eoi_pulse(eoi_pulse), .ack_idx(ack_idx)
   );

   always #5 clk = ~clk;

   // sel: 0..3 = ICW1..ICW4, 4 = OCW1
   task automatic wr(input int sel, input logic [7:0] d);
      @(negedge clk);
      data_in = d;
      if (sel == 4) ocw1_wr = 1'b1;
      else          icw_wr = 4'(1 << sel);
      @(negedge clk);
      icw_wr  = '0;
      ocw1_wr = 1'b0;
   endtask

   task automatic cfg(input logic [7:0] i1, i2, i3, i4, o1);
      wr(0, i1); wr(1, i2); wr(2, i3); wr(3, i4); wr(4, o1);
   endtask

   task automatic drive_inta(input logic v);
      @(negedge clk);
      inta_n = v;
      @(posedge clk);
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1;
      total++;
      if ({cas_out, cas_oe, imr, aeoi, ltim, first_ack, second_ack, iv, iv_ready, eoi_pulse, ack_idx} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got imr=%h iv=%h ack_idx=%0d want all zero", imr, iv, ack_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_ack;
      cfg(8'hD5, 8'hE1, 8'h00, 8'hDA, 8'hAA);
      int_req = 1'b1; int_idx = 3'd5;
      drive_inta(1'b0);
      total++;
      if (first_ack !== 1'b1) begin bad++; $display("FAIL mid_first_ack: got %b want 1", first_ack); end
      @(negedge clk);
      rst_n = 1'b0;
      inta_n = 1'b1;
      #1;
      total++;
      if ({cas_out, cas_oe, imr, aeoi, ltim, first_ack, second_ack, iv, iv_ready, eoi_pulse, ack_idx} !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got imr=%h aeoi=%b ack_idx=%0d want all zero", imr, aeoi, ack_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_inta(1'b0);
      total++;
      if (first_ack !== 1'b1 || second_ack !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_idle: got first=%b second=%b want first=1 second=0", first_ack, second_ack);
      end
      drive_inta(1'b1);
   endtask

   task automatic test_config;
      wr(0, 8'h0A);
      total++;
      if (ltim !== 1'b1) begin bad++; $display("FAIL ltim_set: got %b want 1", ltim); end
      cfg(8'hD5, 8'hE1, 8'h00, 8'hDA, 8'hAA);
      total++;
      if (imr !== 8'hAA || ltim !== 1'b0 || aeoi !== 1'b1) begin
         bad++;
         $display("FAIL config: got imr=%h ltim=%b aeoi=%b want imr=aa ltim=0 aeoi=1", imr, ltim, aeoi);
      end
   endtask

   task automatic test_normal_ack;
      cfg(8'hD5, 8'hE1, 8'h00, 8'hDA, 8'hAA);
      int_req = 1'b1; int_idx = 3'd1;
      drive_inta(1'b0);
      total++;
      if (first_ack !== 1'b1 || second_ack !== 1'b0) begin
         bad++; $display("FAIL first_pulse: got first=%b second=%b want 1 0", first_ack, second_ack);
      end
      tick();
      total++;
      if (first_ack !== 1'b0) begin bad++; $display("FAIL first_pulse_width: got %b want 0", first_ack); end
      drive_inta(1'b1);
      total++;
      if (second_ack !== 1'b0 || iv_ready !== 1'b0) begin
         bad++; $display("FAIL ack1_rise_ignored: got second=%b ready=%b want 0 0", second_ack, iv_ready);
      end
      drive_inta(1'b0);
      total++;
      if (second_ack !== 1'b1 || iv !== 8'hE1 || iv_ready !== 1'b1) begin
         bad++; $display("FAIL second_pulse: got second=%b iv=%h ready=%b want 1 e1 1", second_ack, iv, iv_ready);
      end
      tick();
      total++;
      if (second_ack !== 1'b0 || iv_ready !== 1'b1) begin
         bad++; $display("FAIL ready_hold: got second=%b ready=%b want 0 1", second_ack, iv_ready);
      end
      drive_inta(1'b1);
      total++;
      if (iv_ready !== 1'b0 || eoi_pulse !== 1'b1 || ack_idx !== 3'd1) begin
         bad++; $display("FAIL auto_eoi: got ready=%b eoi=%b idx=%0d want 0 1 1", iv_ready, eoi_pulse, ack_idx);
      end
      tick();
      total++;
      if (eoi_pulse !== 1'b0) begin bad++; $display("FAIL eoi_width: got %b want 0", eoi_pulse); end
   endtask

   task automatic test_spurious;
      cfg(8'hD5, 8'hE1, 8'h00, 8'hDA, 8'hAA);
      int_req = 1'b0; int_idx = 3'd5;
      drive_inta(1'b0);
      total++;
      if (ack_idx !== 3'd7) begin bad++; $display("FAIL spurious_idx: got %0d want 7", ack_idx); end
      int_req = 1'b1; int_idx = 3'd2;
      drive_inta(1'b1);
      drive_inta(1'b0);
      total++;
      if (iv !== 8'hE7) begin bad++; $display("FAIL spurious_iv: got %h want e7", iv); end
      drive_inta(1'b1);
   endtask

   task automatic test_cascade;
      sp_n = 1'b1;
      cfg(8'h11, 8'hE1, 8'hFF, 8'h01, 8'h00);
      int_req = 1'b1; int_idx = 3'd3;
      drive_inta(1'b0);
`ifdef PIC_CASCADE_EN
      total++;
      if (cas_out !== 3'd3 || cas_oe !== 1'b1) begin
         bad++; $display("FAIL master_cas: got cas_out=%0d oe=%b want 3 1", cas_out, cas_oe);
      end
      drive_inta(1'b1);
      drive_inta(1'b0);
      total++;
      if (iv_ready !== 1'b0 || iv !== 8'hE3 || cas_oe !== 1'b1) begin
         bad++; $display("FAIL master_no_ready: got ready=%b iv=%h oe=%b want 0 e3 1", iv_ready, iv, cas_oe);
      end
      drive_inta(1'b1);
      total++;
      if (cas_oe !== 1'b0 || eoi_pulse !== 1'b0) begin
         bad++; $display("FAIL master_release: got oe=%b eoi=%b want 0 0", cas_oe, eoi_pulse);
      end
      for (int k = 0; k < 2; k++) begin
         sp_n = 1'b0;
         cas_in = (k == 0) ? 3'd3 : 3'd2;
         cfg(8'h11, 8'hE1, 8'h03, 8'h01, 8'h00);
         drive_inta(1'b0);
         drive_inta(1'b1);
         drive_inta(1'b0);
         total++;
         if (iv_ready !== (k == 0) || cas_oe !== 1'b0) begin
            bad++; $display("FAIL slave_sel cas_in=%0d: got ready=%b oe=%b want %b 0", cas_in, iv_ready, cas_oe, k == 0);
         end
         drive_inta(1'b1);
      end
      sp_n = 1'b1;
`else
      total++;
      if (cas_out !== 3'd0 || cas_oe !== 1'b0) begin
         bad++; $display("FAIL nocas_drive: got cas_out=%0d oe=%b want 0 0", cas_out, cas_oe);
      end
      drive_inta(1'b1);
      drive_inta(1'b0);
      total++;
      if (iv_ready !== 1'b1 || iv !== 8'hE3) begin
         bad++; $display("FAIL nocas_ready: got ready=%b iv=%h want 1 e3", iv_ready, iv);
      end
      drive_inta(1'b1);
`endif
   endtask

   task automatic test_icw1_abort;
      cfg(8'hD5, 8'hE1, 8'h00, 8'hDA, 8'hAA);
      int_req = 1'b1; int_idx = 3'd4;
      drive_inta(1'b0);
      drive_inta(1'b1);
      @(negedge clk);
      inta_n = 1'b0;
      icw_wr = 4'b0001;
      data_in = 8'hD5;
      tick();
      total++;
      if (first_ack !== 1'b0 || second_ack !== 1'b0 || imr !== 8'h00 || aeoi !== 1'b0) begin
         bad++; $display("FAIL icw1_priority: got first=%b second=%b imr=%h aeoi=%b want 0 0 00 0",
                         first_ack, second_ack, imr, aeoi);
      end
      @(negedge clk);
      icw_wr = '0;
      drive_inta(1'b1);
      drive_inta(1'b0);
      total++;
      if (first_ack !== 1'b1 || second_ack !== 1'b0) begin
         bad++; $display("FAIL abort_restart: got first=%b second=%b want 1 0", first_ack, second_ack);
      end
      drive_inta(1'b1);
      drive_inta(1'b0);
      total++;
      if (second_ack !== 1'b1 || iv !== 8'h04 || iv_ready !== 1'b1) begin
         bad++; $display("FAIL abort_vector: got second=%b iv=%h ready=%b want 1 04 1", second_ack, iv, iv_ready);
      end
      drive_inta(1'b1);
      total++;
      if (eoi_pulse !== 1'b0 || iv_ready !== 1'b0) begin
         bad++; $display("FAIL abort_no_eoi: got eoi=%b ready=%b want 0 0", eoi_pulse, iv_ready);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_ack();
      test_config();
      test_normal_ack();
      test_spurious();
      test_cascade();
      test_icw1_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
